// File: rtl/myterminal_pkg.sv
// Shared sequence-word definitions for the myterminal transmit path.
package myterminal_pkg;

  localparam int SEQ_WIDTH     = 35;
  localparam int SEQ_COUNT_MSB = 34;
  localparam int SEQ_COUNT_LSB = 32;
  localparam int SEQ_MAX_BYTES = 4;

  localparam int SRC_KEYBOARD = 0;
  localparam int SRC_MOUSE    = 1;
  localparam int SRC_REPLY    = 2;

  typedef struct packed {
    logic [SEQ_COUNT_MSB-SEQ_COUNT_LSB:0] count;
    logic [SEQ_COUNT_LSB-1:0]             bytes;
  } seq_t;

  // sequence_to_bytes never sends more than four bytes; larger counts saturate
  function automatic seq_t seq_clamp(input seq_t s);
    seq_t r;
    r = s;
    if (int'(s.count) > SEQ_MAX_BYTES)
      r.count = (SEQ_COUNT_MSB-SEQ_COUNT_LSB+1)'(SEQ_MAX_BYTES);
    return r;
  endfunction

endpackage

// File: rtl/serial_sequence_arbiter_rr_pick.sv
// Combinational circular priority encoder: first set request after 'last', wrapping.
module rr_pick #(
  parameter  int N     = 3,
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] last,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  always_comb begin
    int c;
    gnt = '0;
    idx = last;
    any = 1'b0;
    c   = 0;
    for (int k = 1; k <= N; k++) begin
      c = (int'(last) + k) % N;
      if (!any && req[c]) begin
        any    = 1'b1;
        gnt[c] = 1'b1;
        idx    = IDX_W'(c);
      end
    end
  end

endmodule

// File: rtl/serial_sequence_arbiter.sv
// Round-robin arbiter forwarding whole sequences from N sources into one holding register.
// Optional host flow control: define SEQ_ARB_XOFF_EN.
module serial_sequence_arbiter
  import myterminal_pkg::*;
#(
  parameter  int N_SOURCES = 3,
  parameter  int SEQ_WIDTH = myterminal_pkg::SEQ_WIDTH,
  localparam int IDX_W     = (N_SOURCES > 1) ? $clog2(N_SOURCES) : 1
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic [N_SOURCES*SEQ_WIDTH-1:0] in_data,
  input  logic [N_SOURCES-1:0]           in_available,
  output logic [N_SOURCES-1:0]           in_ready,
  input  logic                           host_xoff,
  input  logic                           receiver_ready,
  output logic [SEQ_WIDTH-1:0]           out_data,
  output logic                           out_data_available,
  output logic [IDX_W-1:0]               last_grant
);

  typedef enum logic {EMPTY, FULL} state_t;

  state_t               state, state_nxt;
  seq_t                 out_q;
  seq_t                 src_word [N_SOURCES];
  logic [N_SOURCES-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_any;
  logic                 xoff;
  logic                 grant_en;
  logic                 take;
  logic                 load;

  for (genvar i = 0; i < N_SOURCES; i++) begin : g_src
    assign src_word[i] = in_data[i*SEQ_WIDTH +: SEQ_WIDTH];
  end

`ifdef SEQ_ARB_XOFF_EN
  logic [1:0] xoff_sync;
  always_ff @(posedge clk) begin
    if (reset) xoff_sync <= '0;
    else       xoff_sync <= {xoff_sync[0], host_xoff};
  end
  assign xoff = xoff_sync[1];
`else
  logic unused_xoff;
  assign unused_xoff = host_xoff;
  assign xoff        = 1'b0;
`endif

  rr_pick #(.N(N_SOURCES)) u_pick (
    .req  (in_available),
    .last (last_grant),
    .gnt  (pick_gnt),
    .idx  (pick_idx),
    .any  (pick_any)
  );

  // A held word keeps draining under xoff; only new grants are blocked.
  assign grant_en = !reset && !xoff && (state == EMPTY || receiver_ready);
  assign take     = grant_en && pick_any;
  assign load     = take && (src_word[pick_idx].count != '0);
  assign in_ready = take ? pick_gnt : '0;

  // Empty words are swallowed: a drain that coincides with one still empties the register.
  always_comb begin
    state_nxt = state;
    if (load)
      state_nxt = FULL;
    else if (state == FULL && receiver_ready)
      state_nxt = EMPTY;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= EMPTY;
      out_q      <= '0;
      last_grant <= IDX_W'(N_SOURCES-1);
    end else begin
      state <= state_nxt;
      if (load) out_q      <= seq_clamp(src_word[pick_idx]);
      if (take) last_grant <= pick_idx;
    end
  end

  assign out_data           = out_q;
  assign out_data_available = (state == FULL);

endmodule

// File: tb/tb_serial_sequence_arbiter.sv
// Vector-table bench with a scoreboard of expected output words for serial_sequence_arbiter.
module tb_serial_sequence_arbiter;
  import myterminal_pkg::*;

  localparam int N = 3;
  localparam int W = 35;

  localparam logic [W-1:0] WK = {3'd1, 32'h6100_0000};
  localparam logic [W-1:0] WM = {3'd2, 32'h1B5B_0000};
  localparam logic [W-1:0] WR = {3'd3, 32'h1B5B_4300};
  localparam logic [W-1:0] WZ = {3'd0, 32'h0000_0000};
  localparam logic [W-1:0] WC = {3'd7, 32'hAABB_CCDD};

  logic             clk = 1'b0;
  logic             reset;
  logic [N*W-1:0]   in_data;
  logic [N-1:0]     in_available;
  logic [N-1:0]     in_ready;
  logic             host_xoff;
  logic             receiver_ready;
  logic [W-1:0]     out_data;
  logic             out_data_available;
  logic [1:0]       last_grant;

  serial_sequence_arbiter #(.N_SOURCES(N), .SEQ_WIDTH(W)) dut (
    .clk                (clk),
    .reset              (reset),
    .in_data            (in_data),
    .in_available       (in_available),
    .in_ready           (in_ready),
    .host_xoff          (host_xoff),
    .receiver_ready     (receiver_ready),
    .out_data           (out_data),
    .out_data_available (out_data_available),
    .last_grant         (last_grant)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic                rst;
    logic [N-1:0]        avail;
    logic                rr;
    logic [N-1:0][W-1:0] data;
    logic [N-1:0]        exp_ready;
    logic                exp_oda;
  } vec_t;

  vec_t       vecs[$];
  logic [W-1:0] sb[$];
  int         n_chk  = 0;
  int         n_fail = 0;

  task automatic chk(input string name, input int row, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s row %0d: got %h want %h", name, row, got, want);
    end
  endtask

  function automatic logic [W-1:0] expect_word(input logic [W-1:0] w);
    logic [2:0] c;
    c = w[34:32];
    if (c > 3'd4) c = 3'd4;
    return {c, w[31:0]};
  endfunction

  function automatic vec_t mk(input logic rst, input logic [N-1:0] avail, input logic rr,
                              input logic [N-1:0][W-1:0] data, input logic [N-1:0] er, input logic eo);
    vec_t v;
    v.rst = rst; v.avail = avail; v.rr = rr; v.data = data; v.exp_ready = er; v.exp_oda = eo;
    return v;
  endfunction

  initial begin
    logic [N-1:0][W-1:0] d;
    vec_t v;

    d[SRC_KEYBOARD] = WK;
    d[SRC_MOUSE]    = WM;
    d[SRC_REPLY]    = WR;

    // single request from the mouse, then drain
    vecs.push_back(mk(0, 3'b010, 1, d, 3'b010, 0));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 1));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 0));
    vecs.push_back(mk(1, 3'b111, 1, d, 3'b000, 0));
    // all three busy with a streaming receiver
    vecs.push_back(mk(0, 3'b111, 1, d, 3'b001, 0));
    vecs.push_back(mk(0, 3'b111, 1, d, 3'b010, 1));
    vecs.push_back(mk(0, 3'b111, 1, d, 3'b100, 1));
    vecs.push_back(mk(0, 3'b111, 1, d, 3'b001, 1));
    vecs.push_back(mk(0, 3'b111, 1, d, 3'b010, 1));
    vecs.push_back(mk(0, 3'b111, 1, d, 3'b100, 1));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 1));
    // receiver stalls for ten cycles while full, then drain+reload together
    vecs.push_back(mk(0, 3'b111, 0, d, 3'b001, 0));
    for (int i = 0; i < 10; i++) vecs.push_back(mk(0, 3'b111, 0, d, 3'b000, 1));
    vecs.push_back(mk(0, 3'b111, 1, d, 3'b010, 1));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 1));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 0));
    // zero-length word from the keyboard is swallowed
    d[SRC_KEYBOARD] = WZ;
    vecs.push_back(mk(0, 3'b011, 1, d, 3'b001, 0));
    vecs.push_back(mk(0, 3'b010, 1, d, 3'b010, 0));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 1));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 0));
    // oversize count saturates to four
    d[SRC_REPLY] = WC;
    vecs.push_back(mk(0, 3'b100, 1, d, 3'b100, 0));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 1));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 0));
    // reset while holding a stalled word discards it
    d[SRC_KEYBOARD] = WK;
    vecs.push_back(mk(0, 3'b001, 0, d, 3'b001, 0));
    vecs.push_back(mk(0, 3'b000, 0, d, 3'b000, 1));
    vecs.push_back(mk(1, 3'b111, 0, d, 3'b000, 1));
    vecs.push_back(mk(0, 3'b111, 1, d, 3'b001, 0));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 1));
    vecs.push_back(mk(0, 3'b000, 1, d, 3'b000, 0));

    reset = 1'b1; in_available = '0; receiver_ready = 1'b0; in_data = '0; host_xoff = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_oda", -1, 64'(out_data_available), 64'(0));
    chk("reset_out_data", -1, 64'(out_data), 64'(0));
    chk("reset_last_grant", -1, 64'(last_grant), 64'(SRC_REPLY));
    in_available = 3'b111;
    #1;
    chk("reset_in_ready", -1, 64'(in_ready), 64'(0));

    for (int r = 0; r < vecs.size(); r++) begin
      v = vecs[r];
      reset = v.rst; in_available = v.avail; receiver_ready = v.rr; in_data = v.data;
      #1;
      chk("in_ready", r, 64'(in_ready), 64'(v.exp_ready));
      chk("out_data_available", r, 64'(out_data_available), 64'(v.exp_oda));
      if (v.exp_oda) begin
        if (sb.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL scoreboard row %0d: output valid with no expected word", r);
        end else begin
          chk("out_data", r, 64'(out_data), 64'(sb[0]));
          if (v.rr) void'(sb.pop_front());
        end
      end
      if (!v.rst)
        for (int s = 0; s < N; s++)
          if (v.exp_ready[s] && v.data[s][34:32] != 3'd0) sb.push_back(expect_word(v.data[s]));
      @(posedge clk);
      #1;
      if (v.rst) sb.delete();
    end

    chk("final_last_grant", -1, 64'(last_grant), 64'(SRC_KEYBOARD));
    chk("scoreboard_drained", -1, 64'(sb.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
